// File: rtl/page_sequencer_pkg.sv
// Shared page encodings, pixel constants and helpers for the screen sequencer.
// Page order: START -> LOAD -> PLAY -> OVER -> START.
package page_sequencer_pkg;

  typedef enum logic [1:0] {
    PAGE_START = 2'b00,
    PAGE_PLAY  = 2'b01,
    PAGE_OVER  = 2'b10,
    PAGE_LOAD  = 2'b11
  } page_e;

  localparam logic [15:0] BLACK = 16'h0000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic page_e next_page(input page_e p);
    page_e n;
    unique case (p)
      PAGE_START: n = PAGE_LOAD;
      PAGE_LOAD:  n = PAGE_PLAY;
      PAGE_PLAY:  n = PAGE_OVER;
      PAGE_OVER:  n = PAGE_START;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/page_sequencer_frame_counter.sv
// Saturating frame_start counter with synchronous clear.
// Clear wins over increment; the count holds at all-ones.
module page_sequencer_frame_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/page_sequencer.sv
// Screen FSM: START -> LOAD -> PLAY -> OVER, page changes only on frame_start.
// Define START_BLINK_EN to blink the start/over prompt every BLINK_FRAMES frames.
import page_sequencer_pkg::*;

module page_sequencer #(
  parameter int LOCK_FRAMES = 30,
  parameter int OVER_FRAMES = 120
`ifdef START_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic        key_valid,
  input  logic        snake_dead,
  input  logic [15:0] start_pix_data,
  input  logic [15:0] game_pix_data,
  input  logic [15:0] over_pix_data,
  output logic [15:0] pix_data,
  output logic [1:0]  page,
  output logic        game_rst,
  output logic        game_en,
  output logic        blink_on
);

  localparam int CNT_W =
    $clog2(max_int(LOCK_FRAMES, OVER_FRAMES) + 2);
  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] OVER_C = CNT_W'(OVER_FRAMES);

  page_e             state;
  page_e             state_d;
  logic              pend;
  logic              pend_d;
  logic              accept;
  logic              go;
  logic [CNT_W-1:0]  frame_cnt;
  logic              game_rst_d;
  logic              game_en_d;
  logic [15:0]       pix_d;

  page_sequencer_frame_counter #(
    .W(CNT_W)
  ) u_frame_cnt (
    .clk (vga_clk),
    .rst (sys_rst),
    .clr (go),
    .inc (frame_start),
    .cnt (frame_cnt)
  );

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state    <= PAGE_START;
      page     <= PAGE_START;
      pend     <= 1'b0;
      pix_data <= BLACK;
      game_rst <= 1'b0;
      game_en  <= 1'b0;
    end else begin
      state    <= state_d;
      page     <= state_d;
      pend     <= pend_d;
      pix_data <= pix_d;
      game_rst <= game_rst_d;
      game_en  <= game_en_d;
    end
  end

  // LOAD always commits at the next frame; a same-cycle event commits too
  always_comb begin
    accept = 1'b0;
    unique case (state)
      PAGE_START: accept = key_valid && (frame_cnt > LOCK_C);
      PAGE_LOAD:  accept = 1'b1;
      PAGE_PLAY:  accept = snake_dead;
      PAGE_OVER:  accept = key_valid && (frame_cnt > OVER_C);
    endcase
    go      = frame_start && (pend || accept);
    state_d = go ? next_page(state) : state;
    pend_d  = go ? 1'b0 : (pend || accept);
  end

  always_comb begin
    game_rst_d = (state_d == PAGE_LOAD);
    game_en_d  = (state_d == PAGE_PLAY) && !pend_d;
    pix_d      = BLACK;
    if (pix_valid) begin
      unique case (state)
        PAGE_START: pix_d = start_pix_data;
        PAGE_PLAY:  pix_d = game_pix_data;
        PAGE_OVER:  pix_d = over_pix_data;
        PAGE_LOAD:  pix_d = BLACK;
      endcase
    end
  end

`ifdef START_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST =
    BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_act;
  logic               blink_wrap;

  assign blink_act  = (state == PAGE_START) || (state == PAGE_OVER);
  assign blink_wrap = blink_act && frame_start && !go &&
                      (blink_cnt == BLINK_LAST);

  page_sequencer_frame_counter #(
    .W(BLINK_W)
  ) u_blink_cnt (
    .clk (vga_clk),
    .rst (sys_rst),
    .clr (go || blink_wrap || !blink_act),
    .inc (frame_start),
    .cnt (blink_cnt)
  );

  always_ff @(posedge vga_clk) begin
    if (sys_rst || go || !blink_act) begin
      blink_on <= 1'b1;
    end else if (blink_wrap) begin
      blink_on <= ~blink_on;
    end
  end
`else
  assign blink_on = 1'b1;
`endif

endmodule

// File: tb/tb_page_sequencer.sv
// Bench for page_sequencer: directed scenarios plus random traffic
// against a frame-level behavioural model.
module tb_page_sequencer;

  localparam int LOCK  = 30;
  localparam int OVER  = 120;
  localparam int BLINK = 4;

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic        key_valid = 1'b0;
  logic        snake_dead = 1'b0;
  logic [15:0] start_pix_data = '0;
  logic [15:0] game_pix_data = '0;
  logic [15:0] over_pix_data = '0;
  logic [15:0] pix_data;
  logic [1:0]  page;
  logic        game_rst;
  logic        game_en;
  logic        blink_on;

  int n_checks = 0;
  int n_fail = 0;
  bit rand_pix = 1'b1;
  bit model_ok = 1'b0;

  page_sequencer #(
    .LOCK_FRAMES(LOCK),
    .OVER_FRAMES(OVER)
`ifdef START_BLINK_EN
    ,
    .BLINK_FRAMES(BLINK)
`endif
  ) dut (
    .vga_clk        (vga_clk),
    .sys_rst        (sys_rst),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .key_valid      (key_valid),
    .snake_dead     (snake_dead),
    .start_pix_data (start_pix_data),
    .game_pix_data  (game_pix_data),
    .over_pix_data  (over_pix_data),
    .pix_data       (pix_data),
    .page           (page),
    .game_rst       (game_rst),
    .game_en        (game_en),
    .blink_on       (blink_on)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: page as a plain index into a cyclic page list, frames as an int
  int          m_idx;
  int          m_frames;
  bit          m_armed;
  int          m_bframes;
  logic [15:0] m_pix;
  logic [1:0]  m_page;
  logic        m_rst;
  logic        m_en;
  logic        m_blink;
  logic [1:0]  order [4] = '{2'b00, 2'b11, 2'b01, 2'b10};

  always @(posedge vga_clk) begin
    if (sys_rst) begin
      m_idx = 0; m_frames = 0; m_armed = 0; m_bframes = 0;
      m_pix = '0; m_rst = 0; m_en = 0; m_blink = 1;
      model_ok = 1'b1;
    end else begin
      bit ev;
      bit commit;
      logic [1:0] cur;
      cur = order[m_idx];
      if (!pix_valid)       m_pix = '0;
      else if (cur == 2'b00) m_pix = start_pix_data;
      else if (cur == 2'b01) m_pix = game_pix_data;
      else if (cur == 2'b10) m_pix = over_pix_data;
      else                   m_pix = '0;
      if (cur == 2'b00)      ev = key_valid && (m_frames > LOCK);
      else if (cur == 2'b10) ev = key_valid && (m_frames > OVER);
      else if (cur == 2'b01) ev = snake_dead;
      else                   ev = 1'b1;
      m_armed = m_armed || ev;
      commit = frame_start && m_armed;
      if (commit) begin
        m_idx = (m_idx + 1) % 4;
        m_frames = 0; m_armed = 0; m_bframes = 0; m_blink = 1;
      end else if (frame_start) begin
        m_frames++;
`ifdef START_BLINK_EN
        if (cur == 2'b00 || cur == 2'b10) begin
          m_bframes++;
          if (m_bframes == BLINK) begin
            m_blink = !m_blink;
            m_bframes = 0;
          end
        end
`endif
      end
      m_rst = (order[m_idx] == 2'b11);
      m_en  = (order[m_idx] == 2'b01) && !m_armed;
    end
    m_page = order[m_idx];
  end

  always @(negedge vga_clk) begin
    if (model_ok) begin
      chk("pix_data", pix_data, m_pix);
      chk("page", 16'(page), 16'(m_page));
      chk("game_rst", 16'(game_rst), 16'(m_rst));
      chk("game_en", 16'(game_en), 16'(m_en));
      chk("blink_on", 16'(blink_on), 16'(m_blink));
    end
  end

  task automatic step(input bit fs, input bit kv, input bit sd);
    frame_start = fs;
    key_valid = kv;
    snake_dead = sd;
    if (rand_pix) begin
      pix_valid = 1'($urandom_range(0, 1));
      start_pix_data = 16'($urandom);
      game_pix_data = 16'($urandom);
      over_pix_data = 16'($urandom);
    end
    @(posedge vga_clk);
    #1;
    frame_start = 0;
    key_valid = 0;
    snake_dead = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0);
      repeat (3) step(0, 0, 0);
    end
  endtask

  initial begin
    sys_rst = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    sys_rst = 0;
    chk("rst_page", 16'(page), 16'h0);
    chk("rst_pix", pix_data, 16'h0);
    chk("rst_game_rst", 16'(game_rst), 16'h0);
    chk("rst_game_en", 16'(game_en), 16'h0);
    chk("rst_blink", 16'(blink_on), 16'h1);

    frames(10);
    step(0, 1, 0);
    frames(1);
    chk("lock_key10", 16'(page), 16'h0);
    frames(20);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("load_page", 16'(page), 16'h3);
    chk("load_rst", 16'(game_rst), 16'h1);
    chk("load_en", 16'(game_en), 16'h0);
    repeat (3) step(0, 0, 0);
    chk("load_rst_hold", 16'(game_rst), 16'h1);
    step(1, 0, 0);
    chk("play_page", 16'(page), 16'h1);
    chk("play_rst", 16'(game_rst), 16'h0);
    chk("play_en", 16'(game_en), 16'h1);

    frames(5);
    step(0, 1, 1);
    chk("dead_en", 16'(game_en), 16'h0);
    chk("dead_page", 16'(page), 16'h1);
    step(1, 0, 0);
    chk("over_page", 16'(page), 16'h2);

    frames(60);
    step(0, 1, 0);
    frames(1);
    chk("over_key60", 16'(page), 16'h2);
    frames(60);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("over_exit", 16'(page), 16'h0);
    chk("over_exit_blink", 16'(blink_on), 16'h1);

    rand_pix = 0;
    pix_valid = 1;
    start_pix_data = 16'h5746;
    step(0, 0, 0);
    chk("mux_start", pix_data, 16'h5746);
    pix_valid = 0;
    step(0, 0, 0);
    chk("mux_blank", pix_data, 16'h0000);
    rand_pix = 1;

    frames(4);
`ifdef START_BLINK_EN
    chk("blink_off", 16'(blink_on), 16'h0);
`else
    chk("blink_off", 16'(blink_on), 16'h1);
`endif
    frames(4);
    chk("blink_on", 16'(blink_on), 16'h1);

    // Counter must saturate, not wrap back under the lockout
    frames(140);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("sat_load", 16'(page), 16'h3);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("sat_play", 16'(page), 16'h1);

    sys_rst = 1;
    step(0, 0, 0);
    sys_rst = 0;
    chk("midrst_page", 16'(page), 16'h0);
    chk("midrst_en", 16'(game_en), 16'h0);
    frames(30);
    step(0, 1, 0);
    frames(2);
    chk("midrst_lock", 16'(page), 16'h0);

    for (int i = 0; i < 20000; i++) begin
      sys_rst = ($urandom_range(0, 4999) == 0);
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 39) == 0));
    end
    sys_rst = 0;
    step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
